// File: rtl/divider_arbiter.sv
// Shares one sequential divider between NUM_REQ requesters.
// Round-robin grant, divide-by-zero trap and hung-divider watchdog.
module divider_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [NUM_REQ-1:0]                req_valid_in,
    output logic [NUM_REQ-1:0]                req_ready_out,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] dividend_in,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  divisor_in,
    output logic [NUM_REQ-1:0]                resp_valid_out,
    output logic [DIVIDEND_WIDTH-1:0]         quotient_out,
    output logic [DIVISOR_WIDTH-1:0]          remainder_out,
    output logic                              error_out,
    output logic [DIVIDEND_WIDTH-1:0]         div_dividend_out,
    output logic [DIVISOR_WIDTH-1:0]          div_divisor_out,
    output logic                              div_start_out,
    input  logic [DIVIDEND_WIDTH-1:0]         div_quotient_in,
    input  logic [DIVISOR_WIDTH-1:0]          div_remainder_in,
    input  logic                              div_valid_in,
    input  logic                              div_error_in,
    input  logic                              div_busy_in
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             ptr_q, ptr_d;
    logic [PW-1:0]             gnt_q, gnt_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DIVIDEND_WIDTH-1:0] dvd_q, dvd_d;
    logic [DIVISOR_WIDTH-1:0]  dvs_q, dvs_d;
    logic [NUM_REQ-1:0]        resp_q, resp_d;
    logic [DIVIDEND_WIDTH-1:0] quo_q, quo_d;
    logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
    logic                      err_q, err_d;

    logic [2*NUM_REQ-1:0]      dbl;
    logic [NUM_REQ-1:0]        rot;
    logic [PW-1:0]             off;
    logic [PW:0]               sum;
    logic [PW-1:0]             sel;
    logic                      found;
    logic [DIVIDEND_WIDTH-1:0] sel_dvd;
    logic [DIVISOR_WIDTH-1:0]  sel_dvs;
    logic                      start;

    // Rotate valids so the pointer position is bit 0, take the lowest set bit.
    always_comb begin
        dbl   = {req_valid_in, req_valid_in} >> ptr_q;
        rot   = dbl[NUM_REQ-1:0];
        found = 1'b0;
        off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = PW'(k);
            end
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= (PW+1)'(NUM_REQ)) begin
            sum = sum - (PW+1)'(NUM_REQ);
        end
        sel     = sum[PW-1:0];
        sel_dvd = '0;
        sel_dvs = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel == PW'(k)) begin
                sel_dvd = dividend_in[k*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
                sel_dvs = divisor_in[k*DIVISOR_WIDTH +: DIVISOR_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        resp_d  = '0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d = sel;
                    dvd_d = sel_dvd;
                    dvs_d = sel_dvs;
                    if (sel_dvs == '0) begin
                        state_d = RESPOND;
                        resp_d  = NUM_REQ'(1) << sel;
                        quo_d   = '0;
                        rem_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!div_busy_in) begin
                    start   = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (div_error_in) begin
                    state_d = RESPOND;
                    resp_d  = NUM_REQ'(1) << gnt_q;
                    quo_d   = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                end else if (div_valid_in) begin
                    state_d = RESPOND;
                    resp_d  = NUM_REQ'(1) << gnt_q;
                    quo_d   = div_quotient_in;
                    rem_d   = div_remainder_in;
                    err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 2)) begin
                    // Response lands TIMEOUT_CYCLES after the start pulse.
                    state_d = RESPOND;
                    resp_d  = NUM_REQ'(1) << gnt_q;
                    quo_d   = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                end
            end
            RESPOND: begin
                ptr_d   = (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            resp_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            resp_q  <= resp_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // Ready is combinational; gated so reset forces every output low at once.
    assign req_ready_out    = (found && state_q == IDLE && rst_in) ?
                              (NUM_REQ'(1) << sel) : '0;
    assign div_start_out    = start;
    assign div_dividend_out = dvd_q;
    assign div_divisor_out  = dvs_q;
    assign resp_valid_out   = resp_q;
    assign quotient_out     = quo_q;
    assign remainder_out    = rem_q;
    assign error_out        = err_q;

endmodule
